// File: rtl/ascensor_pkg.sv
// rtl/ascensor_pkg.sv - shared constants, cab state type and sensor decode helpers
package ascensor_pkg;

    localparam int N_PISOS = 10;
    localparam int W_PISO  = 4;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        PUERTA   = 2'd3
    } estado_cabina_t;

    function automatic logic onehot_valido(input logic [N_PISOS-1:0] v);
        return (v != '0) && ((v & (v - N_PISOS'(1))) == '0);
    endfunction

    // Only meaningful when the input is one-hot; callers gate with onehot_valido.
    function automatic logic [W_PISO-1:0] onehot_a_idx(input logic [N_PISOS-1:0] v);
        logic [W_PISO-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (v[i]) begin
                idx = idx | W_PISO'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/temporizador_puerta.sv
// rtl/temporizador_puerta.sv - door dwell down counter, reloadable while the door is open
module temporizador_puerta #(
    parameter int T_PUERTA = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic cargar,
    input  logic habilitar,
    output logic fin
);

    localparam int W_CNT = $clog2(T_PUERTA);

    logic [W_CNT-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cargar) begin
            r_cnt <= W_CNT'(T_PUERTA - 1);
        end else if (habilitar && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W_CNT'(1);
        end
    end

    assign fin = (r_cnt == '0);

endmodule

// File: rtl/control_cabina.sv
// rtl/control_cabina.sv - cab motion and door FSM feeding floor status back to the scheduler
module control_cabina
    import ascensor_pkg::*;
#(
    parameter int T_PUERTA = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_PISO-1:0]  estado_final,
    input  logic [N_PISOS-1:0] s,
    input  logic [N_PISOS-1:0] sensor_piso,
    input  logic               boton_abrir,
    output logic [W_PISO-1:0]  estado_inicial,
    output logic               cambio_piso,
    output logic               esperar,
    output logic               motor_subir,
    output logic               motor_bajar,
    output logic               puerta_abierta,
    output logic [N_PISOS-1:0] piso_atendido
);

    localparam logic [N_PISOS-1:0] UNO     = N_PISOS'(1);
    localparam logic [W_PISO-1:0]  PISO_UP = W_PISO'(N_PISOS - 1);

    estado_cabina_t     r_estado;
    logic [W_PISO-1:0]  r_piso;
    logic               r_cambio;
    logic               r_puerta;
    logic               r_subir;
    logic               r_bajar;
    logic [N_PISOS-1:0] r_atendido;

    estado_cabina_t     w_estado_sig;
    logic [W_PISO-1:0]  w_piso_sig;
    logic               w_cambio_sig;
    logic               w_puerta_sig;
    logic               w_subir_sig;
    logic               w_bajar_sig;
    logic [N_PISOS-1:0] w_atendido_sig;
    logic               w_cargar;
    logic               w_fin;

    logic               w_valido;
    logic [W_PISO-1:0]  w_f;
    logic               w_nuevo;
    logic               w_final_ok;

    assign w_valido   = onehot_valido(sensor_piso);
    assign w_f        = onehot_a_idx(sensor_piso);
    assign w_nuevo    = w_valido && (w_f != r_piso);
    assign w_final_ok = (estado_final < W_PISO'(N_PISOS));

    always_comb begin
        w_estado_sig   = r_estado;
        w_piso_sig     = r_piso;
        w_cambio_sig   = 1'b0;
        w_puerta_sig   = 1'b0;
        w_subir_sig    = 1'b0;
        w_bajar_sig    = 1'b0;
        w_atendido_sig = '0;
        w_cargar       = 1'b0;

        case (r_estado)
            REPOSO: begin
                // Resync after reset or drift takes a whole cycle so the request check sees the true floor.
                if (w_nuevo) begin
                    w_piso_sig = w_f;
                end else if (s[r_piso]) begin
                    w_estado_sig   = PUERTA;
                    w_puerta_sig   = 1'b1;
                    w_atendido_sig = UNO << r_piso;
                    w_cargar       = 1'b1;
                end else if (w_final_ok && (estado_final > r_piso)) begin
                    w_estado_sig = SUBIENDO;
                    w_subir_sig  = 1'b1;
                end else if (w_final_ok && (estado_final < r_piso)) begin
                    w_estado_sig = BAJANDO;
                    w_bajar_sig  = 1'b1;
                end
            end

            SUBIENDO: begin
                w_subir_sig = 1'b1;
                if (w_nuevo) begin
                    w_piso_sig   = w_f;
                    w_cambio_sig = 1'b1;
                    if (s[w_f] || (w_f == estado_final)) begin
                        w_subir_sig    = 1'b0;
                        w_estado_sig   = PUERTA;
                        w_puerta_sig   = 1'b1;
                        w_atendido_sig = UNO << w_f;
                        w_cargar       = 1'b1;
                    end else if (!w_final_ok || (estado_final < w_f) || (w_f == PISO_UP)) begin
                        w_subir_sig  = 1'b0;
                        w_estado_sig = REPOSO;
                    end
                end
            end

            BAJANDO: begin
                w_bajar_sig = 1'b1;
                if (w_nuevo) begin
                    w_piso_sig   = w_f;
                    w_cambio_sig = 1'b1;
                    if (s[w_f] || (w_f == estado_final)) begin
                        w_bajar_sig    = 1'b0;
                        w_estado_sig   = PUERTA;
                        w_puerta_sig   = 1'b1;
                        w_atendido_sig = UNO << w_f;
                        w_cargar       = 1'b1;
                    end else if (!w_final_ok || (estado_final > w_f) || (w_f == '0)) begin
                        w_bajar_sig  = 1'b0;
                        w_estado_sig = REPOSO;
                    end
                end
            end

            PUERTA: begin
                w_puerta_sig = 1'b1;
                if (boton_abrir) begin
                    w_cargar = 1'b1;
                end else if (w_fin) begin
                    w_puerta_sig = 1'b0;
                    w_estado_sig = REPOSO;
                end
            end

            default: begin
                w_estado_sig = REPOSO;
            end
        endcase
    end

    temporizador_puerta #(
        .T_PUERTA (T_PUERTA)
    ) u_temporizador (
        .clk       (clk),
        .rst       (rst),
        .cargar    (w_cargar),
        .habilitar (r_estado == PUERTA),
        .fin       (w_fin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado   <= REPOSO;
            r_piso     <= '0;
            r_cambio   <= 1'b0;
            r_puerta   <= 1'b0;
            r_subir    <= 1'b0;
            r_bajar    <= 1'b0;
            r_atendido <= '0;
        end else begin
            r_estado   <= w_estado_sig;
            r_piso     <= w_piso_sig;
            r_cambio   <= w_cambio_sig;
            r_puerta   <= w_puerta_sig;
            r_subir    <= w_subir_sig;
            r_bajar    <= w_bajar_sig;
            r_atendido <= w_atendido_sig;
        end
    end

    assign estado_inicial = r_piso;
    assign cambio_piso    = r_cambio;
    assign esperar        = r_puerta;
    assign puerta_abierta = r_puerta;
    assign motor_subir    = r_subir;
    assign motor_bajar    = r_bajar;
    assign piso_atendido  = r_atendido;

endmodule

// File: tb/tb_control_cabina.sv
// tb/tb_control_cabina.sv - directed self-checking bench for control_cabina
module tb_control_cabina;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] estado_final;
    logic [9:0] s;
    logic [9:0] sensor_piso;
    logic       boton_abrir;
    logic [3:0] estado_inicial;
    logic       cambio_piso;
    logic       esperar;
    logic       motor_subir;
    logic       motor_bajar;
    logic       puerta_abierta;
    logic [9:0] piso_atendido;

    int checks   = 0;
    int failures = 0;

    control_cabina #(.T_PUERTA(50)) dut (
        .clk            (clk),
        .rst            (rst),
        .estado_final   (estado_final),
        .s              (s),
        .sensor_piso    (sensor_piso),
        .boton_abrir    (boton_abrir),
        .estado_inicial (estado_inicial),
        .cambio_piso    (cambio_piso),
        .esperar        (esperar),
        .motor_subir    (motor_subir),
        .motor_bajar    (motor_bajar),
        .puerta_abierta (puerta_abierta),
        .piso_atendido  (piso_atendido)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if ((motor_subir === 1'b1 && motor_bajar === 1'b1) ||
                ((motor_subir === 1'b1 || motor_bajar === 1'b1) && puerta_abierta === 1'b1)) begin
                failures++;
                $display("FAIL exclusion: subir=%b bajar=%b puerta=%b required no overlap",
                         motor_subir, motor_bajar, puerta_abierta);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; estado_final = 4'd15; s = '0; sensor_piso = 10'h004; boton_abrir = 1'b0;
        tick;
        rst = 1'b0;
        checks++;
        if ({estado_inicial, cambio_piso, esperar, motor_subir, motor_bajar, puerta_abierta, piso_atendido} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: est=%0d cp=%b esp=%b su=%b ba=%b pa=%b at=%h required all 0",
                     estado_inicial, cambio_piso, esperar, motor_subir, motor_bajar, puerta_abierta, piso_atendido);
        end
        tick;
        checks++;
        if (estado_inicial !== 4'd2 || cambio_piso !== 1'b0) begin
            failures++;
            $display("FAIL reset_resync: est=%0d cp=%b required est=2 cp=0", estado_inicial, cambio_piso);
        end
        tick;
        checks++;
        if ({motor_subir, motor_bajar, puerta_abierta, esperar} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle: su=%b ba=%b pa=%b esp=%b required 0", motor_subir, motor_bajar, puerta_abierta, esperar);
        end
    endtask

    task automatic test_subida;
        int pulsos;
        int n;
        logic [9:0] pasos [6];
        pasos[0] = 10'h000; pasos[1] = 10'h002; pasos[2] = 10'h000;
        pasos[3] = 10'h004; pasos[4] = 10'h000; pasos[5] = 10'h008;
        sensor_piso = 10'h001;
        tick;
        estado_final = 4'd3; s = 10'h008;
        tick;
        checks++;
        if (estado_inicial !== 4'd0 || motor_subir !== 1'b1) begin
            failures++;
            $display("FAIL up_start: est=%0d su=%b required est=0 su=1", estado_inicial, motor_subir);
        end
        pulsos = 0;
        for (int i = 0; i < 6; i++) begin
            sensor_piso = pasos[i];
            tick;
            if (cambio_piso === 1'b1) pulsos++;
            if (i == 2) begin
                checks++;
                if (cambio_piso !== 1'b0 || estado_inicial !== 4'd1 || motor_subir !== 1'b1) begin
                    failures++;
                    $display("FAIL up_floor1: cp=%b est=%0d su=%b required cp=0 est=1 su=1", cambio_piso, estado_inicial, motor_subir);
                end
            end
            if (i == 3) begin
                checks++;
                if (cambio_piso !== 1'b1 || estado_inicial !== 4'd2) begin
                    failures++;
                    $display("FAIL up_floor2: cp=%b est=%0d required cp=1 est=2", cambio_piso, estado_inicial);
                end
            end
        end
        checks++;
        if (estado_inicial !== 4'd3 || motor_subir !== 1'b0 || esperar !== 1'b1 ||
            puerta_abierta !== 1'b1 || piso_atendido !== 10'h008) begin
            failures++;
            $display("FAIL up_arrive: est=%0d su=%b esp=%b pa=%b at=%h required est=3 su=0 esp=1 pa=1 at=008",
                     estado_inicial, motor_subir, esperar, puerta_abierta, piso_atendido);
        end
        checks++;
        if (pulsos != 3) begin
            failures++;
            $display("FAIL up_pulses: got %0d required 3", pulsos);
        end
        s = '0;
        n = 1;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (i == 0) begin
                checks++;
                if (piso_atendido !== 10'h000) begin
                    failures++;
                    $display("FAIL up_served_len: at=%h required 000", piso_atendido);
                end
            end
            if (esperar === 1'b1) n++;
            else break;
        end
        checks++;
        if (n != 50) begin
            failures++;
            $display("FAIL up_dwell: esperar cycles=%0d required 50", n);
        end
        checks++;
        if (puerta_abierta !== 1'b0 || motor_subir !== 1'b0 || motor_bajar !== 1'b0) begin
            failures++;
            $display("FAIL up_after_door: pa=%b su=%b ba=%b required 0", puerta_abierta, motor_subir, motor_bajar);
        end
    endtask

    task automatic test_parada_intermedia;
        estado_final = 4'd7; s = 10'h010;
        tick;
        checks++;
        if (motor_subir !== 1'b1) begin
            failures++;
            $display("FAIL mid_start: su=%b required 1", motor_subir);
        end
        tick;
        checks++;
        if (cambio_piso !== 1'b0 || estado_inicial !== 4'd3 || motor_subir !== 1'b1) begin
            failures++;
            $display("FAIL mid_departure: cp=%b est=%0d su=%b required cp=0 est=3 su=1", cambio_piso, estado_inicial, motor_subir);
        end
        sensor_piso = 10'h000; tick;
        sensor_piso = 10'h010; tick;
        checks++;
        if (estado_inicial !== 4'd4 || cambio_piso !== 1'b1 || motor_subir !== 1'b0 ||
            puerta_abierta !== 1'b1 || piso_atendido !== 10'h010) begin
            failures++;
            $display("FAIL mid_stop: est=%0d cp=%b su=%b pa=%b at=%h required est=4 cp=1 su=0 pa=1 at=010",
                     estado_inicial, cambio_piso, motor_subir, puerta_abierta, piso_atendido);
        end
        estado_final = 4'd4; s = '0;
        for (int i = 0; i < 300 && esperar === 1'b1; i++) tick;
        checks++;
        if (esperar !== 1'b0) begin
            failures++;
            $display("FAIL mid_door_close: esp=%b required 0 within budget", esperar);
        end
    endtask

    task automatic test_boton;
        int c;
        s = 10'h010;
        tick;
        checks++;
        if (esperar !== 1'b1 || piso_atendido !== 10'h010) begin
            failures++;
            $display("FAIL btn_open: esp=%b at=%h required esp=1 at=010", esperar, piso_atendido);
        end
        s = '0;
        c = 0;
        for (int i = 0; i < 300; i++) begin
            boton_abrir = (c >= 30 && c < 50);
            tick;
            if (esperar === 1'b1) c++;
            else break;
        end
        boton_abrir = 1'b0;
        checks++;
        if (c + 1 != 100) begin
            failures++;
            $display("FAIL btn_dwell: esperar cycles=%0d required 100", c + 1);
        end
    endtask

    task automatic test_sensor_invalido;
        estado_final = 4'd7;
        tick;
        sensor_piso = 10'h00C; tick;
        checks++;
        if (cambio_piso !== 1'b0 || estado_inicial !== 4'd4 || motor_subir !== 1'b1) begin
            failures++;
            $display("FAIL inv_00C: cp=%b est=%0d su=%b required cp=0 est=4 su=1", cambio_piso, estado_inicial, motor_subir);
        end
        sensor_piso = 10'h3FF; tick;
        checks++;
        if (cambio_piso !== 1'b0 || estado_inicial !== 4'd4) begin
            failures++;
            $display("FAIL inv_3FF: cp=%b est=%0d required cp=0 est=4", cambio_piso, estado_inicial);
        end
        sensor_piso = 10'h020; tick;
        checks++;
        if (cambio_piso !== 1'b1 || estado_inicial !== 4'd5 || motor_subir !== 1'b1 || puerta_abierta !== 1'b0) begin
            failures++;
            $display("FAIL inv_pass5: cp=%b est=%0d su=%b pa=%b required cp=1 est=5 su=1 pa=0",
                     cambio_piso, estado_inicial, motor_subir, puerta_abierta);
        end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (motor_subir !== 1'b0 || motor_bajar !== 1'b0 || estado_inicial !== 4'd0 || puerta_abierta !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: su=%b ba=%b est=%0d pa=%b required all 0", motor_subir, motor_bajar, estado_inicial, puerta_abierta);
        end
        estado_final = 4'd15;
        tick;
        checks++;
        if (estado_inicial !== 4'd5 || cambio_piso !== 1'b0 || motor_subir !== 1'b0) begin
            failures++;
            $display("FAIL rst_resync: est=%0d cp=%b su=%b required est=5 cp=0 su=0", estado_inicial, cambio_piso, motor_subir);
        end
    endtask

    task automatic test_bajada;
        estado_final = 4'd2;
        tick;
        checks++;
        if (motor_bajar !== 1'b1 || motor_subir !== 1'b0) begin
            failures++;
            $display("FAIL down_start: ba=%b su=%b required ba=1 su=0", motor_bajar, motor_subir);
        end
        sensor_piso = 10'h000; tick;
        sensor_piso = 10'h010; tick;
        checks++;
        if (estado_inicial !== 4'd4 || cambio_piso !== 1'b1 || motor_bajar !== 1'b1) begin
            failures++;
            $display("FAIL down_floor4: est=%0d cp=%b ba=%b required est=4 cp=1 ba=1", estado_inicial, cambio_piso, motor_bajar);
        end
        estado_final = 4'd15;
        sensor_piso = 10'h008; tick;
        checks++;
        if (estado_inicial !== 4'd3 || cambio_piso !== 1'b1 || motor_bajar !== 1'b0 || puerta_abierta !== 1'b0) begin
            failures++;
            $display("FAIL down_abort: est=%0d cp=%b ba=%b pa=%b required est=3 cp=1 ba=0 pa=0",
                     estado_inicial, cambio_piso, motor_bajar, puerta_abierta);
        end
        tick;
        checks++;
        if (motor_bajar !== 1'b0 || motor_subir !== 1'b0 || cambio_piso !== 1'b0) begin
            failures++;
            $display("FAIL down_idle: ba=%b su=%b cp=%b required 0", motor_bajar, motor_subir, cambio_piso);
        end
    endtask

    initial begin
        test_reset;
        test_subida;
        test_parada_intermedia;
        test_boton;
        test_sensor_invalido;
        test_reset_mid;
        test_bajada;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
